swan64_key_sequencer_128: RTL
=============================

# swan64_key_sequencer_128

Sequential round-key generator for SWAN64 with a 128-bit key. It loads a master key on a start pulse and steps the 128-bit key schedule once per accepted round key. Each 32-bit subkey is delivered over a valid/ready handshake to the round datapath, with round index and last-round flag. With the configuration macro enabled, it also emits subkeys in reverse order for decryption.

## Interface
- `ROUNDS`, 64, number of round keys per run; legal range 1..255.
- `PD`, 24, key rotation distance in bits.
- `DELTA0`, 32'h9e3779b9, delta increment per round.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; accepted only in IDLE.
- `key_in` in 128: master key, bit 0 = MSB; sampled on the accepted `start`.
- `dec` in 1: order select, sampled with `start`; 1 = reverse order.
- `busy` out 1: high in every state except IDLE.
- `sk_valid` out 1: subkey available.
- `sk_ready` in 1: consumer accepts the subkey.
- `sk` out 32: current round subkey.
- `sk_round` out 8: index of `sk`, 1..ROUNDS.
- `sk_last` out 1: high while the final subkey of the run is presented.
- `done` out 1: one-cycle pulse after the final handshake.

## Operation
- State registers: `K` (128 bits), `D` (32 bits), round counter `R` (8 bits).
- Forward step (K,D)→(K',D'):
  - `D' = D + DELTA0` mod 2^32.
  - `T = {K[128-PD:127], K[0:127-PD]}` (rotate right by PD).
  - `K' = {T[0:95], T[96:127] + D'}`.
- Inverse step (K',D')→(K,D):
  - `T = {K'[0:95], K'[96:127] - D'}`.
  - `K = {T[PD:127], T[0:PD-1]}` (rotate left by PD).
  - `D = D' - DELTA0`.
- All arithmetic is mod 2^32. Initial state: `K_0 = key_in`, `D_0 = 0`. `sk_i = K_i[96:127]`.
- FSM states:
  - IDLE: `start` loads `K = step(key_in, 0)`, `R = 1`. Go to RUN, or PRESCAN if `dec` = 1 and the macro is enabled.
  - PRESCAN: applies one forward step per cycle and increments `R` until `R == ROUNDS`, then goes to REVRUN. No output in this state.
  - RUN: `sk_valid = 1`. On a handshake (`sk_valid & sk_ready`): if `R == ROUNDS`, go to DONE; otherwise apply a forward step and `R += 1`.
  - REVRUN: `sk_valid = 1`. On a handshake: if `R == 1`, go to DONE; otherwise apply an inverse step and `R -= 1`.
  - DONE: `done = 1` for one cycle, then go to IDLE.
- `sk = K[96:127]`, `sk_round = R`.
- `sk_last = sk_valid & (R == ROUNDS)` in RUN, or `sk_valid & (R == 1)` in REVRUN.
- While `sk_valid = 1` and `sk_ready = 0`, `sk`, `sk_round` and `sk_last` hold stable.
- `start` while `busy = 1` is ignored; no queuing.
- `start` in the DONE cycle is ignored.
- `ROUNDS = 1`: PRESCAN takes zero cycles, and the single subkey has `sk_last = 1`.

## Timing
- Reset values (any state): FSM = IDLE; `K`, `D`, `R` = 0; `sk_valid`, `busy`, `done`, `sk_last` = 0; `sk` = 0; `sk_round` = 0.
- Reset mid-run aborts immediately. No `done` is produced and nothing resumes.
- Forward order: `start` at cycle t gives `sk_1` valid at t+1. With `sk_ready` held high, one subkey per cycle with no bubbles; `done` at t+ROUNDS+1.
- Reverse order: `sk_ROUNDS` valid at t+ROUNDS; `done` one cycle after the handshake with `R == 1`.
- `busy` rises the cycle after the accepted `start` and falls the cycle after `done`.

## Configuration
- `SWAN_KS_DEC_EN` defined: PRESCAN and REVRUN states and the inverse-step logic are compiled in, and `dec` selects the order.
- `SWAN_KS_DEC_EN` not defined: the port `dec` is present but ignored (treated as 0). Only IDLE/RUN/DONE exist, and the inverse-step logic is absent.

## Test plan
- Forward, all-zero key, `sk_ready` = 1: `sk_1 = 0x9e3779b9` at t+1 with `sk_round = 1`; `sk_2 = 0x3c6ef410` at t+2; `sk_last` with `sk_round = 64`; `done` at t+65.
- Backpressure: hold `sk_ready` = 0 for 5 cycles at round 3. `sk`, `sk_round` = 3 and `sk_valid` stay stable; round 4 appears the cycle after `sk_ready` rises.
- `start` pulsed at round 10 with a different key is ignored. The run completes with the original key sequence and `done` fires exactly once.
- Assert `rst` at round 20. All outputs are 0 in the same cycle; a subsequent `start` gives `sk_1 = 0x9e3779b9` again (zero key).
- With `SWAN_KS_DEC_EN`, zero key, `dec` = 1: first valid at t+64 with `sk_round = 64`, equal to the forward `sk_64`. The sequence is the exact reverse of the forward run; the final `sk = 0x9e3779b9` has `sk_last = 1`.
- Random keys, 100 runs in each order: the reverse sequence equals the reversed forward sequence, and `sk_round` decrements 64→1.

Source files
------------

// File: rtl/swan64_key_sequencer_128.sv
// SWAN64 128-bit key schedule sequencer: streams one 32-bit subkey per valid/ready handshake.
// Define SWAN_KS_DEC_EN to add reverse-order (decryption) delivery selected by dec.
module swan64_key_sequencer_128 #(
  parameter int          ROUNDS = 64,
  parameter int          PD     = 24,
  parameter logic [31:0] DELTA0 = 32'h9e3779b9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         dec,
  output logic         busy,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic [31:0]  sk,
  output logic [7:0]   sk_round,
  output logic         sk_last,
  output logic         done
);

  localparam logic [7:0] ROUNDS_L = 8'(ROUNDS);

`ifdef SWAN_KS_DEC_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_PRESCAN, S_REVRUN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  logic dec_unused;
  assign dec_unused = dec;
`endif

  state_t       state_reg, state_next;
  logic [127:0] k_reg, k_next;
  logic [31:0]  d_reg, d_next;
  logic [7:0]   r_reg, r_next;
  logic [31:0]  d_fwd;
  logic [127:0] k_fwd;

  // Key bit 0 is the MSB, so the spec's "rotate right" is a plain right rotate
  // of the [127:0] vector and the subkey word is the low 32 bits.
  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [31:0] d);
    logic [127:0] t;
    t = (k >> PD) | (k << (128 - PD));
    return {t[127:32], t[31:0] + d};
  endfunction

`ifdef SWAN_KS_DEC_EN
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [31:0] d);
    logic [127:0] t;
    t = {k[127:32], k[31:0] - d};
    return (t << PD) | (t >> (128 - PD));
  endfunction
`endif

  assign d_fwd = d_reg + DELTA0;
  assign k_fwd = fwd_step(k_reg, d_fwd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    d_next     = d_reg;
    r_next     = r_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          d_next     = DELTA0;
          k_next     = fwd_step(key_in, DELTA0);
          r_next     = 8'd1;
          state_next = S_RUN;
`ifdef SWAN_KS_DEC_EN
          // With a single round the prescan has nothing to do.
          if (dec) state_next = (ROUNDS_L == 8'd1) ? S_REVRUN : S_PRESCAN;
`endif
        end
      end
      S_RUN: begin
        if (sk_ready) begin
          if (r_reg == ROUNDS_L) begin
            state_next = S_DONE;
          end else begin
            k_next = k_fwd;
            d_next = d_fwd;
            r_next = r_reg + 8'd1;
          end
        end
      end
`ifdef SWAN_KS_DEC_EN
      S_PRESCAN: begin
        k_next = k_fwd;
        d_next = d_fwd;
        r_next = r_reg + 8'd1;
        if (r_reg + 8'd1 == ROUNDS_L) state_next = S_REVRUN;
      end
      S_REVRUN: begin
        if (sk_ready) begin
          if (r_reg == 8'd1) begin
            state_next = S_DONE;
          end else begin
            k_next = inv_step(k_reg, d_reg);
            d_next = d_reg - DELTA0;
            r_next = r_reg - 8'd1;
          end
        end
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign sk       = k_reg[31:0];
  assign sk_round = r_reg;

`ifdef SWAN_KS_DEC_EN
  assign sk_valid = (state_reg == S_RUN) || (state_reg == S_REVRUN);
  assign sk_last  = ((state_reg == S_RUN) && (r_reg == ROUNDS_L)) ||
                    ((state_reg == S_REVRUN) && (r_reg == 8'd1));
`else
  assign sk_valid = (state_reg == S_RUN);
  assign sk_last  = (state_reg == S_RUN) && (r_reg == ROUNDS_L);
`endif

endmodule
